// File: rtl/pe.sv
// Weight-stationary multiply-accumulate processing element.
// Each accepted operand computes psum_in + iact_in * weight and forwards the
// activation and the new partial sum, registered, to the neighbouring PEs.
// Optional build macro: PE_SATURATE_EN. When it is defined, out-of-range
// results clamp to the PSUM_W limits. When it is undefined, results wrap.
module pe #(
  parameter int DATA_W = 16,
  parameter int PSUM_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              weight_load,
  input  logic [DATA_W-1:0] weight,
  input  logic [DATA_W-1:0] iact_in,
  input  logic [PSUM_W-1:0] psum_in,
  input  logic              valid_in,
  output logic [DATA_W-1:0] iact_out,
  output logic [PSUM_W-1:0] psum_out,
  output logic              valid_out,
  output logic              ovf
);

  localparam int PROD_W  = 2 * DATA_W;
  localparam int EXACT_W = ((PSUM_W > PROD_W) ? PSUM_W : PROD_W) + 1;
  localparam int TOP_W   = EXACT_W - PSUM_W + 1;

  logic [DATA_W-1:0]         weight_q;
  logic signed [DATA_W-1:0]  w_eff;
  logic signed [PROD_W-1:0]  product;
  logic signed [EXACT_W-1:0] exact;
  logic [TOP_W-1:0]          top_bits;
  logic                      out_of_range;
  logic                      accept;
  logic [PSUM_W-1:0]         result;
`ifdef PE_SATURATE_EN
  logic                      pos_ovf;
  logic                      neg_ovf;
`endif

  // A weight presented together with weight_load is used in the same cycle.
  always_comb begin
    w_eff = weight_load ? weight : weight_q;
  end

  // Full-precision product and sum, wide enough that neither can wrap.
  // The result fits PSUM_W only when every bit from the PSUM_W sign bit up is identical.
  always_comb begin
    product      = PROD_W'($signed(iact_in)) * PROD_W'(w_eff);
    exact        = EXACT_W'(product) + EXACT_W'($signed(psum_in));
    top_bits     = exact[EXACT_W-1:PSUM_W-1];
    out_of_range = !((&top_bits) || !(|top_bits));
    accept       = en && valid_in;
  end

`ifdef PE_SATURATE_EN
  // Clamp out-of-range sums to the nearest representable limit.
  always_comb begin
    pos_ovf = out_of_range && !exact[EXACT_W-1];
    neg_ovf = out_of_range &&  exact[EXACT_W-1];
    if (pos_ovf) begin
      result = {1'b0, {(PSUM_W-1){1'b1}}};
    end else if (neg_ovf) begin
      result = {1'b1, {(PSUM_W-1){1'b0}}};
    end else begin
      result = exact[PSUM_W-1:0];
    end
  end
`else
  // Two's-complement wrap: keep only the low PSUM_W bits of the exact sum.
  always_comb begin
    result = exact[PSUM_W-1:0];
  end
`endif

  // The stored weight updates whenever it is loaded, independent of en and valid_in.
  always_ff @(posedge clk) begin
    if (rst) begin
      weight_q <= '0;
    end else if (weight_load) begin
      weight_q <= weight;
    end
  end

  // Forwarding pipeline. A stall holds everything, and a bubble clears only valid_out.
  always_ff @(posedge clk) begin
    if (rst) begin
      iact_out  <= '0;
      psum_out  <= '0;
      valid_out <= 1'b0;
    end else if (en) begin
      if (valid_in) begin
        iact_out  <= iact_in;
        psum_out  <= result;
        valid_out <= 1'b1;
      end else begin
        valid_out <= 1'b0;
      end
    end
  end

  // Sticky overflow flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (accept && out_of_range) begin
      ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pe.sv
// Self-checking bench for pe: directed vectors with literal expectations,
// plus an arithmetic reference model that is compared against the DUT every cycle.
module tb_pe;

`ifdef PE_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        en;
  logic        weight_load;
  logic [15:0] weight;
  logic [15:0] iact_in;
  logic [15:0] psum_in;
  logic        valid_in;
  logic [15:0] iact_out;
  logic [15:0] psum_out;
  logic        valid_out;
  logic        ovf;

  int checks = 0;
  int errors = 0;
  bit checking = 1'b0;

  // Reference model state
  longint m_w = 0;
  longint m_iact = 0;
  longint m_psum = 0;
  bit     m_valid = 1'b0;
  bit     m_ovf = 1'b0;

  pe #(.DATA_W(16), .PSUM_W(16)) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .weight_load(weight_load),
    .weight(weight),
    .iact_in(iact_in),
    .psum_in(psum_in),
    .valid_in(valid_in),
    .iact_out(iact_out),
    .psum_out(psum_out),
    .valid_out(valid_out),
    .ovf(ovf)
  );

  // 10 ns clock period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: integer arithmetic, with wrap or clamp applied to the exact sum
  always @(posedge clk) begin
    longint weff;
    longint ex;
    longint res;
    if (rst) begin
      m_w = 0; m_iact = 0; m_psum = 0; m_valid = 1'b0; m_ovf = 1'b0;
    end else begin
      weff = weight_load ? longint'($signed(weight)) : m_w;
      if (weight_load) m_w = longint'($signed(weight));
      if (en && valid_in) begin
        ex = longint'($signed(psum_in)) + longint'($signed(iact_in)) * weff;
        res = ((ex % 65536) + 65536) % 65536;
        if (res >= 32768) res = res - 65536;
        if (SAT && ex > 32767) res = 32767;
        if (SAT && ex < -32768) res = -32768;
        if (ex > 32767 || ex < -32768) m_ovf = 1'b1;
        m_iact = longint'($signed(iact_in));
        m_psum = res;
        m_valid = 1'b1;
      end else if (en) begin
        m_valid = 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model, 1 ns after the clock edge
  always @(posedge clk) begin
    #1;
    if (checking) begin
      checks++;
      if (longint'($signed(psum_out)) !== m_psum || longint'($signed(iact_out)) !== m_iact ||
          valid_out !== m_valid || ovf !== m_ovf) begin
        errors++;
        $display("[TB] FAIL model_cycle t=%0t: got psum=%0d iact=%0d valid=%b ovf=%b, expected psum=%0d iact=%0d valid=%b ovf=%b",
                 $time, $signed(psum_out), $signed(iact_out), valid_out, ovf, m_psum, m_iact, m_valid, m_ovf);
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive inputs on the falling edge, then wait until just after the next rising edge
  task automatic applyStimulus(input bit r, input bit e, input bit wl, input int w,
                               input int ia, input int ps, input bit v);
    @(negedge clk);
    rst = r; en = e; weight_load = wl;
    weight = 16'(w); iact_in = 16'(ia); psum_in = 16'(ps); valid_in = v;
    @(posedge clk);
    #2;
  endtask

  task automatic checkOutput(input string name, input int e_psum, input int e_iact,
                             input bit e_valid, input bit e_ovf);
    checks++;
    if (int'($signed(psum_out)) !== e_psum || int'($signed(iact_out)) !== e_iact ||
        valid_out !== e_valid || ovf !== e_ovf) begin
      errors++;
      $display("[TB] FAIL %s: got psum=%0d iact=%0d valid=%b ovf=%b, expected psum=%0d iact=%0d valid=%b ovf=%b",
               name, $signed(psum_out), $signed(iact_out), valid_out, ovf, e_psum, e_iact, e_valid, e_ovf);
    end
  endtask

  // Back-to-back operands that are checked only by the reference model
  int tbl_w[8]  = '{3, -7, 0, 32767, -32768, 12, -1, 255};
  int tbl_ia[8] = '{-4, 9, 1234, 2, -1, -300, 32767, 128};
  int tbl_ps[8] = '{17, -50, -9, 1, 0, 4000, -32768, -1};

  initial begin
    rst = 1'b0; en = 1'b0; weight_load = 1'b0;
    weight = '0; iact_in = '0; psum_in = '0; valid_in = 1'b0;

    // Reset with arbitrary inputs, including a weight load that reset must override
    applyStimulus(1, 1, 1, 99, 5, 77, 1);
    checkOutput("reset", 0, 0, 0, 0);
    checking = 1'b1;
    applyStimulus(0, 1, 0, 0, 7, 3, 1);
    checkOutput("post_reset_w0", 3, 7, 1, 0);

    // Signed MAC with a weight loaded in the same cycle
    applyStimulus(0, 1, 1, 1, 10, 5, 1);
    checkOutput("mac_pos", 15, 10, 1, 0);
    applyStimulus(0, 1, 1, -1, 20, 30, 1);
    checkOutput("mac_negw", 10, 20, 1, 0);
    applyStimulus(0, 1, 1, 0, 100, 500, 1);
    checkOutput("mac_zerow", 500, 100, 1, 0);
    applyStimulus(0, 1, 1, -1, -10, 100, 1);
    checkOutput("mac_negneg", 110, -10, 1, 0);

    // Chained accumulation, then use of the stored weight
    applyStimulus(0, 1, 1, 1, 3, 110, 1);
    checkOutput("chain", 113, 3, 1, 0);
    applyStimulus(0, 1, 1, 4, 9, 9, 0);
    checkOutput("load_only", 113, 3, 0, 0);
    applyStimulus(0, 1, 0, 0, 5, 2, 1);
    checkOutput("stored_w", 22, 5, 1, 0);

    // Stall for three cycles with changing inputs; a weight load during the stall still takes effect
    applyStimulus(0, 0, 0, 0, 11, 50, 1);
    checkOutput("stall1", 22, 5, 1, 0);
    applyStimulus(0, 0, 1, 2, 12, 60, 1);
    checkOutput("stall2", 22, 5, 1, 0);
    applyStimulus(0, 0, 0, 0, 13, 70, 0);
    checkOutput("stall3", 22, 5, 1, 0);
    applyStimulus(0, 1, 0, 0, 14, 80, 0);
    checkOutput("bubble", 22, 5, 0, 0);
    applyStimulus(0, 1, 0, 0, 3, 1, 1);
    checkOutput("stall_wload", 7, 3, 1, 0);

    // A zero weight must pass psum through unchanged
    applyStimulus(0, 1, 1, 0, -123, -1234, 1);
    checkOutput("zero_weight", -1234, -123, 1, 0);

    // Overflow cases and the sticky flag
    applyStimulus(0, 1, 1, 200, 200, 0, 1);
    checkOutput("ovf_pos", SAT ? 32767 : -25536, 200, 1, 1);
    applyStimulus(0, 1, 1, 1, 1, 1, 1);
    checkOutput("ovf_sticky", 2, 1, 1, 1);
    applyStimulus(0, 1, 1, 200, -200, -100, 1);
    checkOutput("ovf_neg", SAT ? -32768 : 25436, -200, 1, 1);
    applyStimulus(0, 1, 1, -32768, -32768, 0, 1);
    checkOutput("extreme_prod", SAT ? 32767 : 0, -32768, 1, 1);

    // A reset in the middle of a stream clears everything, including the sticky flag
    applyStimulus(1, 1, 1, 5, 5, 5, 1);
    checkOutput("mid_reset", 0, 0, 0, 0);

    // Exact range boundaries: the limits themselves fit, one beyond them does not
    applyStimulus(0, 1, 1, 1, 32766, 1, 1);
    checkOutput("max_edge", 32767, 32766, 1, 0);
    applyStimulus(0, 1, 1, -1, 32767, -1, 1);
    checkOutput("min_edge", -32768, 32767, 1, 0);
    applyStimulus(0, 1, 1, 1, 1, 32767, 1);
    checkOutput("max_plus1", SAT ? 32767 : -32768, 1, 1, 1);

    // Full-throughput burst, checked cycle by cycle against the model
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 1, 1, tbl_w[i], tbl_ia[i], tbl_ps[i], 1);
    end
    applyStimulus(0, 1, 0, 0, 0, 0, 0);

    @(negedge clk);
    checking = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pe.md
Name: pe

Overview:
- Weight-stationary multiply-accumulate processing element for the systolic-array NPU.
- Each cycle it multiplies the incoming activation by its stored weight and adds the partial sum arriving from the neighbouring PE.
- It forwards the activation and the updated partial sum, registered, to the next PEs in the row and column.
- Array tiles instantiate it in a 2-D grid.

Parameters:
- DATA_W, 16, signed width of activation and weight.
- PSUM_W, 16, signed width of partial sum in/out.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  pipeline advance; low = stall, all data/valid registers hold.
- weight_load  input  1  capture weight into the internal weight register.
- weight  input  DATA_W  signed weight value.
- iact_in  input  DATA_W  signed input activation.
- psum_in  input  PSUM_W  signed incoming partial sum.
- valid_in  input  1  iact_in/psum_in carry a valid operand.
- iact_out  output  DATA_W  registered activation forwarded to the next PE.
- psum_out  output  PSUM_W  registered accumulated partial sum.
- valid_out  output  1  psum_out/iact_out hold a valid result.
- ovf  output  1  sticky arithmetic overflow flag.

Behaviour:
- All state updates happen on the rising clk edge. There are no combinational input-to-output paths.
- Reset (rst=1 at the edge) overrides everything:
  - weight register, iact_out, psum_out, valid_out and ovf all become 0.
  - A reset mid-stream discards any in-flight result.
- Effective weight w_eff:
  - w_eff = weight when weight_load=1 (same-cycle bypass).
  - w_eff = stored weight register otherwise.
- weight_load=1 writes weight into the register at the edge regardless of en or valid_in.
- Compute:
  - product = iact_in * w_eff, full precision, 2*DATA_W signed.
  - exact = psum_in + product, evaluated at 2*DATA_W+1 bits, sign-extended as needed.
  - result = exact truncated (two's-complement wrap) to PSUM_W.
- en=1, valid_in=1: iact_out <= iact_in, psum_out <= result, valid_out <= 1.
- en=1, valid_in=0: iact_out and psum_out hold, valid_out <= 0.
- en=0: iact_out, psum_out and valid_out hold. weight_load is still honoured.
- Latency is exactly 1 cycle from valid_in to valid_out. Throughput is one operand per cycle.
- Zero weight: psum_out = psum_in unchanged, bit-exact.
- Overflow:
  - ovf is set to 1 on any accepted compute (en=1, valid_in=1) where exact lies outside [-2^(PSUM_W-1), 2^(PSUM_W-1)-1].
  - Once set, ovf stays 1 until rst.
- Signed operands at both extremes (e.g. -32768 * -32768) must not wrap inside the product. Only the final PSUM_W result wraps.

Optional Feature:
- Macro PE_SATURATE_EN.
- When defined: on overflow, result clamps to 2^(PSUM_W-1)-1 (positive overflow) or -2^(PSUM_W-1) (negative overflow) instead of wrapping. ovf behaviour is unchanged.
- When undefined: two's-complement wrap as above.
- Non-overflowing results are identical in both builds.

Test Plan:
- Reset: assert rst with arbitrary inputs for one cycle -> iact_out=0, psum_out=0, valid_out=0, ovf=0. Next cycle with weight_load=0, iact_in=7, psum_in=3, valid_in=1 -> psum_out=3 (stored weight 0).
- Signed MAC sequence, weight_load=1 each cycle, en=1, valid_in=1, checked one cycle later:
  - (iact 10, psum 5, w 1) -> psum_out 15, iact_out 10.
  - (20, 30, -1) -> 10.
  - (100, 500, 0) -> 500.
  - (-10, 100, -1) -> 110.
- Chained accumulate: feed psum_in = previous psum_out (110), iact 3, w 1 -> psum_out 113, iact_out 3. Also load w=4 once, then weight_load=0 with iact 5, psum 2 -> 22 (stored weight used).
- Stall/bubble:
  - en=0 for 3 cycles with changing inputs -> outputs and valid_out frozen.
  - en=1, valid_in=0 -> valid_out=0, psum_out holds last value.
- Overflow: iact 200, w 200, psum 0 -> default build psum_out=-25536, ovf=1. With PE_SATURATE_EN, psum_out=32767, ovf=1. ovf remains 1 after subsequent small ops until rst.
- Negative extreme: iact -200, w 200, psum -100 -> saturating build -32768, wrap build 25436; ovf=1 in both.
